// File: rtl/backbone_pkg.sv
// Shared widths, drain FSM state type and the saturating narrow helper for the GEMM backbone.
package backbone_pkg;

  localparam int ACC_W = 32;
  localparam int OUT_W = 16;

  typedef enum logic {DRN_IDLE, DRN_STREAM} drain_state_e;

  // Clamp a signed accumulator into the signed OUT_W range.
  function automatic logic signed [OUT_W-1:0] sat_narrow(input logic signed [ACC_W-1:0] v);
    logic [ACC_W-OUT_W:0] hi;
    hi = v[ACC_W-1:OUT_W-1];
    if ((&hi) | ~(|hi)) return v[OUT_W-1:0];
    else if (v[ACC_W-1]) return {1'b1, {(OUT_W-1){1'b0}}};
    else return {1'b0, {(OUT_W-1){1'b1}}};
  endfunction

endpackage

// File: rtl/systolic_tile_drain_narrow.sv
// Combinational ACC_W -> OUT_W element narrower.
// DRAIN_SAT_EN defined: signed saturation; undefined: two's-complement wrap.
module drain_narrow import backbone_pkg::*; #(
  parameter int ACC_W = backbone_pkg::ACC_W,
  parameter int OUT_W = backbone_pkg::OUT_W
) (
  input  logic signed [ACC_W-1:0] i_val,
  output logic signed [OUT_W-1:0] o_val
);

  // Sign bit of the result plus every discarded bit; all equal means the value fits.
  logic [ACC_W-OUT_W:0] w_hi;
  assign w_hi = i_val[ACC_W-1:OUT_W-1];

`ifdef DRAIN_SAT_EN
  logic w_fits;
  assign w_fits = (&w_hi) | ~(|w_hi);

  always_comb begin
    o_val = i_val[OUT_W-1:0];
    if (!w_fits) begin
      o_val = i_val[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end
`else
  logic w_unused;
  assign w_unused = ^w_hi;
  assign o_val    = i_val[OUT_W-1:0];
`endif

endmodule

// File: rtl/systolic_tile_drain.sv
// Snapshots the finished accumulator tile, clears the array, and streams the tile out row by row.
// Element narrowing follows DRAIN_SAT_EN (see drain_narrow).
//
// state      | meaning
// DRN_IDLE   | no tile held, ready to capture
// DRN_STREAM | presenting buffered rows, one per accepted beat
module systolic_tile_drain import backbone_pkg::*; #(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int ACC_W = backbone_pkg::ACC_W,
  parameter int OUT_W = backbone_pkg::OUT_W,
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      tile_done,
  input  logic signed [ROWS-1:0][COLS-1:0][ACC_W-1:0] c_in,
  output logic                                      tile_ready,
  output logic                                      clr_acc,
  output logic                                      m_valid,
  input  logic                                      m_ready,
  output logic signed [COLS-1:0][OUT_W-1:0]         m_data,
  output logic [RW-1:0]                             m_row,
  output logic                                      m_last,
  output logic                                      err_overrun
);

  drain_state_e                       r_state;
  logic [ROWS-1:0][COLS-1:0][ACC_W-1:0] r_buf;
  logic [RW-1:0]                      r_row;
  logic                               r_valid;
  logic                               r_last;
  logic                               r_clr;
  logic                               r_err;

  logic                               w_beat;
  logic                               w_cap;
  logic [COLS-1:0][ACC_W-1:0]         w_sel;

  // Ready one cycle early on the last beat so back-to-back tiles stream without a bubble.
  assign tile_ready = (r_state == DRN_IDLE) | ((r_state == DRN_STREAM) & r_last & m_ready);
  assign w_cap      = tile_done & tile_ready;
  assign w_beat     = r_valid & m_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= DRN_IDLE;
      r_row   <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_clr   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_clr <= w_cap;
      if (tile_done && !tile_ready) r_err <= 1'b1;
      if (w_cap) begin
        r_buf   <= c_in;
        r_row   <= '0;
        r_valid <= 1'b1;
        r_last  <= (ROWS == 1);
        r_state <= DRN_STREAM;
      end else if (w_beat) begin
        if (r_last) begin
          r_state <= DRN_IDLE;
          r_valid <= 1'b0;
          r_last  <= 1'b0;
          r_row   <= '0;
        end else begin
          r_row  <= r_row + 1'b1;
          r_last <= (r_row == RW'(ROWS-2));
        end
      end
    end
  end

  assign w_sel = r_buf[r_row];

  for (genvar gi = 0; gi < COLS; gi++) begin : g_nar
    drain_narrow #(
      .ACC_W (ACC_W),
      .OUT_W (OUT_W)
    ) u_nar (
      .i_val (w_sel[gi]),
      .o_val (m_data[gi])
    );
  end

  assign m_valid     = r_valid;
  assign m_row       = r_row;
  assign m_last      = r_last;
  assign clr_acc     = r_clr;
  assign err_overrun = r_err;

endmodule

// File: tb/tb_systolic_tile_drain.sv
// Randomized bench for systolic_tile_drain against a beat-queue reference model.
// Honors DRAIN_SAT_EN the same way the design does.
module tb_systolic_tile_drain;
  import backbone_pkg::*;

  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int AW   = ACC_W;
  localparam int OW   = OUT_W;

  logic                                  clk = 1'b0;
  logic                                  rst;
  logic                                  tile_done;
  logic                                  m_ready;
  logic signed [ROWS-1:0][COLS-1:0][AW-1:0] c_in;
  logic                                  tile_ready;
  logic                                  clr_acc;
  logic                                  m_valid;
  logic [COLS-1:0][OW-1:0]               m_data;
  logic [2:0]                            m_row;
  logic                                  m_last;
  logic                                  err_overrun;

  always #5 clk = ~clk;

  systolic_tile_drain #(
    .ROWS  (ROWS),
    .COLS  (COLS),
    .ACC_W (AW),
    .OUT_W (OW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tile_done   (tile_done),
    .c_in        (c_in),
    .tile_ready  (tile_ready),
    .clr_acc     (clr_acc),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_row       (m_row),
    .m_last      (m_last),
    .err_overrun (err_overrun)
  );

  typedef struct {
    int                  row;
    logic [COLS*OW-1:0]  data;
  } beat_t;

  // Every captured tile becomes ROWS pending beats; the head is what must be on the bus.
  beat_t q[$];
  bit    exp_clr;
  bit    exp_err;
  bit    t5_chk;
  int    n_vec;
  int    n_err;

`ifdef DRAIN_SAT_EN
  localparam logic [OW-1:0] T5_POS = 16'h7FFF;
  localparam logic [OW-1:0] T5_NEG = 16'h8000;
`else
  localparam logic [OW-1:0] T5_POS = 16'h9C40;
  localparam logic [OW-1:0] T5_NEG = 16'h63C0;
`endif

  function automatic logic [OW-1:0] ref_narrow(input longint v);
    longint lim;
    longint m;
    lim = longint'(1) << (OW-1);
`ifdef DRAIN_SAT_EN
    if (v > lim - 1) v = lim - 1;
    else if (v < -lim) v = -lim;
`endif
    m = v % (lim * 2);
    if (m < 0) m = m + lim * 2;
    return m[OW-1:0];
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic push_tile();
    beat_t b;
    for (int r = 0; r < ROWS; r++) begin
      b.row = r;
      for (int c = 0; c < COLS; c++) begin
        b.data[c*OW +: OW] = ref_narrow(longint'($signed(c_in[r][c])));
      end
      q.push_back(b);
    end
  endtask

  task automatic fill_seq();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        c_in[r][c] = AW'(r * COLS + c);
  endtask

  task automatic fill_rand();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        if ($urandom_range(0, 2) == 0) c_in[r][c] = AW'($urandom);
        else c_in[r][c] = AW'(int'($urandom_range(0, 60000)) - 30000);
      end
  endtask

  // One clock: drive, check mid-cycle, then advance the model at the edge.
  task automatic step(input bit a_rst, input bit a_td, input bit a_rdy);
    bit v;
    bit tr;
    rst       = a_rst;
    tile_done = a_td;
    m_ready   = a_rdy;
    #4;
    v  = (q.size() > 0);
    tr = (q.size() == 0) || (q.size() == 1 && a_rdy);
    chk("m_valid", 256'(m_valid), 256'(v));
    chk("tile_ready", 256'(tile_ready), 256'(tr));
    chk("clr_acc", 256'(clr_acc), 256'(exp_clr));
    chk("err_overrun", 256'(err_overrun), 256'(exp_err));
    if (v) begin
      chk("m_row", 256'(m_row), 256'(q[0].row));
      chk("m_last", 256'(m_last), 256'(q.size() == 1));
      chk("m_data", 256'(m_data), 256'(q[0].data));
    end else begin
      chk("m_row_idle", 256'(m_row), 256'(0));
      chk("m_last_idle", 256'(m_last), 256'(0));
    end
    if (t5_chk) begin
      chk("narrow_pos", 256'(m_data[0]), 256'(T5_POS));
      chk("narrow_neg", 256'(m_data[1]), 256'(T5_NEG));
      t5_chk = 1'b0;
    end
    @(posedge clk);
    if (a_rst) begin
      q.delete();
      exp_clr = 1'b0;
      exp_err = 1'b0;
    end else begin
      if (a_td && !tr) exp_err = 1'b1;
      if (v && a_rdy) void'(q.pop_front());
      if (a_td && tr) push_tile();
      exp_clr = a_td && tr;
    end
    #1;
  endtask

  initial begin
    int k;
    n_vec = 0; n_err = 0; t5_chk = 1'b0;
    exp_clr = 1'b0; exp_err = 1'b0;
    rst = 1'b1; tile_done = 1'b0; m_ready = 1'b0; c_in = '0;
    repeat (2) @(posedge clk);
    #1;
    step(1'b1, 1'b0, 1'b0);

    // ascending tile, always ready
    fill_seq();
    step(1'b0, 1'b1, 1'b1);
    repeat (10) step(1'b0, 1'b0, 1'b1);

    // same tile under 1,0,0 backpressure
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 30; i++) step(1'b0, 1'b0, (i % 3) == 0);

    // back-to-back tile on the last beat
    fill_rand();
    step(1'b0, 1'b1, 1'b1);
    k = 0;
    while (q.size() != 1 && k < 20) begin step(1'b0, 1'b0, 1'b1); k++; end
    fill_rand();
    step(1'b0, 1'b1, 1'b1);
    repeat (10) step(1'b0, 1'b0, 1'b1);

    // overrun at row 3
    fill_rand();
    step(1'b0, 1'b1, 1'b1);
    k = 0;
    while (q.size() != 5 && k < 20) begin step(1'b0, 1'b0, 1'b1); k++; end
    fill_rand();
    step(1'b0, 1'b1, 1'b0);
    repeat (12) step(1'b0, 1'b0, 1'b1);

    // narrowing corners
    c_in = '0;
    c_in[0][0] = 32'sd40000;
    c_in[0][1] = -32'sd40000;
    step(1'b0, 1'b1, 1'b1);
    t5_chk = 1'b1;
    repeat (10) step(1'b0, 1'b0, 1'b1);

    // reset during row 4, then a clean tile
    fill_rand();
    step(1'b0, 1'b1, 1'b1);
    k = 0;
    while (q.size() != 4 && k < 20) begin step(1'b0, 1'b0, 1'b1); k++; end
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    fill_rand();
    step(1'b0, 1'b1, 1'b1);
    repeat (10) step(1'b0, 1'b0, 1'b1);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) fill_rand();
      step($urandom_range(0, 150) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 3) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
